// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_pkg : shared types and constants for the MIPS pipeline stages |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mips_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] CMP_SLT = 3'd0;
  localparam logic [2:0] CMP_BEQ = 3'd1;
  localparam logic [2:0] CMP_J   = 3'd2;
  localparam logic [2:0] CMP_BNE = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_req_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_req_timer : wait counter with clear/enable, flags last cycle   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_req_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Asserted during the final permitted wait cycle.
  assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | memory_access_stage : MIPS MEM stage, lw/sw over req/ack data port |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module memory_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ALUout,
  input  logic [DATA_W-1:0] XM_storeData,
  input  logic [4:0]        XM_RD,
  input  logic              XM_lwFlag,
  input  logic              XM_swFlag,
  input  logic [2:0]        XM_compareFlag,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic [4:0]        MW_RD,
  output logic [DATA_W-1:0] MW_result,
  output logic              MW_regWrite,
  output logic              mem_error
);

  mem_state_e r_state;
  mem_state_e w_next;

  logic w_memop;
  logic w_aligned;
  logic w_idle;
  logic w_busy;
  logic w_expired;

  assign w_memop   = XM_lwFlag | XM_swFlag;
  assign w_aligned = (ALUout[1:0] == 2'b00);
  assign w_idle    = (r_state == ST_IDLE);
  assign w_busy    = (r_state == ST_BUSY);
  assign mem_stall = (w_idle && w_memop) || w_busy;

  mem_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_idle && w_memop && w_aligned),
    .i_enable  (w_busy && !dmem_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_memop) w_next = w_aligned ? ST_BUSY : ST_DONE;
      ST_BUSY: if (dmem_ack || w_expired) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      MW_RD       <= '0;
      MW_result   <= '0;
      MW_regWrite <= 1'b0;
      mem_error   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_memop) begin
            MW_RD       <= XM_RD;
            MW_result   <= ALUout;
            MW_regWrite <= (XM_compareFlag == CMP_SLT) && (XM_RD != 5'd0);
          end else if (w_aligned) begin
            // lw takes priority when both flags are raised.
            dmem_req    <= 1'b1;
            dmem_we     <= !XM_lwFlag;
            dmem_addr   <= ALUout;
            dmem_wdata  <= XM_storeData;
            MW_RD       <= XM_RD;
            MW_regWrite <= 1'b0;
          end else begin
            mem_error   <= 1'b1;
            MW_regWrite <= 1'b0;
          end
        end
        ST_BUSY: begin
          // An ack in the expiry cycle still completes the access.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              MW_result   <= dmem_rdata;
              MW_regWrite <= (MW_RD != 5'd0);
            end else begin
              MW_regWrite <= 1'b0;
            end
          end else if (w_expired) begin
            dmem_req    <= 1'b0;
            mem_error   <= 1'b1;
            MW_regWrite <= 1'b0;
          end
        end
        ST_DONE: MW_regWrite <= 1'b0;
        default: MW_regWrite <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire
